// File: rtl/mem_stage.sv
// Memory-access stage and MEM/WB latch: issues dcache requests, holds them until dhit, buffers load data.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN; otherwise stall_cnt reads 0.
module mem_stage #(
  parameter int REGSEL_W = 2
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic                ex_memRd,
  input  logic                ex_memWr,
  input  logic                ex_regWr,
  input  logic [REGSEL_W-1:0] ex_regSel,
  input  logic [4:0]          ex_regDst,
  input  logic                ex_halt,
  input  logic [31:0]         ex_nPC,
  input  logic [31:0]         ex_ALUOut,
  input  logic [31:0]         ex_lui,
  input  logic [31:0]         ex_store,
  input  logic                dhit,
  input  logic [31:0]         dmemload,
  output logic                dmemREN,
  output logic                dmemWEN,
  output logic [31:0]         dmemaddr,
  output logic [31:0]         dmemstore,
  output logic                mem_stall,
  output logic                wb_regWr,
  output logic [REGSEL_W-1:0] wb_regSel,
  output logic [4:0]          wb_regDst,
  output logic [31:0]         wb_nPC,
  output logic [31:0]         wb_ALUOut,
  output logic [31:0]         wb_lui,
  output logic [31:0]         wb_dmemload,
  output logic                wb_halt,
  output logic [31:0]         stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] load_buf;
  logic        acc, adv, capture;

  assign acc       = ex_valid & (ex_memRd | ex_memWr);
  assign dmemaddr  = ex_ALUOut;
  assign dmemstore = ex_store;
  assign mem_stall = acc & (state != DONE) & ~dhit;
  assign adv       = ihit & ~mem_stall;

  always_comb begin
    state_nxt = state;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE, WAIT: begin
        // A load takes precedence when both memRd and memWr are set.
        dmemREN = nRST & acc & ex_memRd;
        dmemWEN = nRST & acc & ex_memWr & ~ex_memRd;
        if (acc & dhit) begin
          state_nxt = ihit ? IDLE : DONE;
          capture   = ~ihit;
        end else if (acc) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (ihit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state       <= IDLE;
      load_buf    <= '0;
      wb_regWr    <= 1'b0;
      wb_regSel   <= '0;
      wb_regDst   <= '0;
      wb_nPC      <= '0;
      wb_ALUOut   <= '0;
      wb_lui      <= '0;
      wb_dmemload <= '0;
      wb_halt     <= 1'b0;
    end else begin
      if (capture) load_buf <= dmemload;
      state <= flush ? IDLE : state_nxt;
      if (flush) begin
        wb_regWr    <= 1'b0;
        wb_regSel   <= '0;
        wb_regDst   <= '0;
        wb_nPC      <= '0;
        wb_ALUOut   <= '0;
        wb_lui      <= '0;
        wb_dmemload <= '0;
        wb_halt     <= 1'b0;
      end else if (adv) begin
        wb_regWr    <= ex_regWr & ex_valid;
        wb_regSel   <= ex_regSel;
        wb_regDst   <= ex_regDst;
        wb_nPC      <= ex_nPC;
        wb_ALUOut   <= ex_ALUOut;
        wb_lui      <= ex_lui;
        wb_dmemload <= (state == DONE) ? load_buf : dmemload;
        wb_halt     <= ex_halt;
      end
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) stall_cnt_q <= '0;
    else if (mem_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
